// File: rtl/mfp_pmod_als_spi_reader.sv
`timescale 1ns / 1ps
// SPI master for the PMOD ALS (ADC081S021): clocks in one 16-bit frame per request
// and presents the 8-bit light value with a one-cycle valid strobe.
module mfp_pmod_als_spi_reader #(
    parameter int unsigned CLK_DIV = 8,
    parameter int unsigned QUIET   = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       sdi,
    output logic       cs_n,
    output logic       sck,
    output logic [7:0] value,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned MaxCnt = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] QuietLast = CntW'(QUIET - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StDone
    } state_e;

    state_e            state;
    logic [CntW-1:0]   cnt;
    logic [4:0]        bit_cnt;
    logic [15:0]       shift;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= StIdle;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            cs_n    <= 1'b1;
            sck     <= 1'b1;
            value   <= 8'h00;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StSetup;
                        cs_n  <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                StSetup: begin
                    if (cnt == DivLast) begin
                        state   <= StShift;
                        sck     <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StShift: begin
                    if (cnt != DivLast) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        // sdi is captured on the same edge that raises sck
                        if (!sck) begin
                            sck     <= 1'b1;
                            shift   <= {shift[14:0], sdi};
                            bit_cnt <= bit_cnt + 5'd1;
                        end else if (bit_cnt == 5'd16) begin
                            state <= StDone;
                            cs_n  <= 1'b1;
                            valid <= 1'b1;
                            value <= shift[12:5];
                        end else begin
                            sck <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (cnt == QuietLast) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
